mem_access_unit: RTL and testbench

//  Multi-cycle load/store controller between the datapath and the word-wide Data_mem.

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
//--------------------------------------------------------------------
// mem_access_pkg : size codes, FSM states and defaults for mem_access_unit
// Rev 1.0
//--------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_e;

  // Size 2'b11 has no defined access width, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_align.sv
//--------------------------------------------------------------------
// lane_align : sub-word lane extraction/extension for loads and lane merge for stores
// Rev 1.0
//--------------------------------------------------------------------
`default_nettype none

module lane_align
  import mem_access_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  lsb;
  logic [31:0] mask;
  logic [31:0] shifted;

  // lsb is the bit position of the addressed lane inside the memory word.
  always_comb begin
    lsb  = 5'd0;
    mask = 32'hFFFF_FFFF;
    case (size_i)
      SZ_BYTE: begin
        lsb  = (BIG_ENDIAN != 0) ? (5'd24 - {offset_i, 3'b000}) : {offset_i, 3'b000};
        mask = 32'h0000_00FF << lsb;
      end
      SZ_HALF: begin
        lsb  = (BIG_ENDIAN != 0) ? (5'd16 - {offset_i[1], 4'b0000}) : {offset_i[1], 4'b0000};
        mask = 32'h0000_FFFF << lsb;
      end
      default: begin
        lsb  = 5'd0;
        mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  always_comb begin
    shifted     = rdata_i >> lsb;
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
    merged_o = (rdata_i & ~mask) | ((wdata_i << lsb) & mask);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//--------------------------------------------------------------------
// mem_access_unit : multi-cycle load/store controller with read-modify-write sub-word stores
// Rev 1.0
//--------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
  parameter int BIG_ENDIAN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_range_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [29:0] DEPTH_IDX = 30'(MEM_DEPTH);

  state_e      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        busy_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        range_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_write_q;
  logic        mem_read_q;

  logic        misalign_d;
  logic        range_d;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    misalign_d = is_misaligned(i_size, i_addr[1:0]);
    range_d    = (i_addr[31:2] >= DEPTH_IDX);
  end

  lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_align (
    .size_i      (size_q),
    .signed_i    (signed_q),
    .offset_i    (addr_q[1:0]),
    .rdata_i     (i_mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // All outputs are registered and set one state ahead of the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      range_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req) begin
            we_q       <= i_we;
            size_q     <= i_size;
            signed_q   <= i_signed;
            addr_q     <= i_addr;
            wdata_q    <= i_wdata;
            busy_q     <= 1'b1;
            mem_addr_q <= {2'b00, i_addr[31:2]};
            if (misalign_d || range_d) begin
              state_q    <= FAULT;
              done_q     <= 1'b1;
              misalign_q <= misalign_d;
              range_q    <= range_d;
            end else if (!i_we) begin
              state_q    <= LOAD;
              mem_read_q <= 1'b1;
            end else if (i_size == SZ_WORD) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= i_wdata;
            end else begin
              state_q    <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q    <= DONE;
          rdata_q    <= load_data;
          mem_read_q <= 1'b0;
          done_q     <= 1'b1;
        end
        RMW_RD: begin
          state_q     <= WRITE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= merged;
        end
        WRITE: begin
          state_q     <= DONE;
          mem_write_q <= 1'b0;
          mem_wdata_q <= 32'h0;
          done_q      <= 1'b1;
        end
        DONE, FAULT: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          misalign_q <= 1'b0;
          range_q    <= 1'b0;
          mem_addr_q <= 32'h0;
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          misalign_q  <= 1'b0;
          range_q     <= 1'b0;
          mem_addr_q  <= 32'h0;
          mem_wdata_q <= 32'h0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_misalign  = misalign_q;
  assign o_range_err = range_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_write = mem_write_q;
  assign o_mem_read  = mem_read_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//--------------------------------------------------------------------
// tb_mem_access_unit : scoreboard bench for mem_access_unit with a behavioural word memory
// Rev 1.0
//--------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int DEPTH = 32;
  localparam int BE    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign, range_err, mem_write, mem_read;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rdata = 32'h0;
  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        rng;
    int          lat;
    int          n_wr;
    int          n_rd;
    logic [31:0] wword;
    logic [31:0] widx;
  } exp_t;
  exp_t sb[$];

  mem_access_unit #(.MEM_DEPTH(DEPTH), .BIG_ENDIAN(BE)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size), .i_signed(sgn),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_misalign(misalign), .o_range_err(range_err), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_write(mem_write), .o_mem_read(mem_read),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) if (mem_write && mem_addr < DEPTH) mem[mem_addr[4:0]] = mem_wdata;
  always @(negedge clk) if (mem_read && mem_write) both_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
    if (BE != 0) return w[31-8*k -: 8];
    return w[8*k +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] b);
    logic [31:0] r;
    r = w;
    if (BE != 0) r[31-8*k -: 8] = b;
    else         r[8*k +: 8] = b;
    return r;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  task automatic access(input logic w_we, input logic [1:0] w_sz, input logic w_sg,
                        input logic [31:0] w_ad, input logic [31:0] w_wd);
    exp_t e;
    logic [31:0] w, v, got_wd, got_wa;
    logic [7:0]  b;
    logic [15:0] h;
    int off, idx, lat, nwr, nrd;
    off = int'(w_ad[1:0]);
    e.mis   = (w_sz == 2'b11) || (w_sz == SZ_HALF && w_ad[0]) || (w_sz == SZ_WORD && w_ad[1:0] != 2'b00);
    e.rng   = (w_ad[31:2] >= DEPTH);
    e.rdata = last_rdata;
    e.n_wr  = 0;
    e.n_rd  = 0;
    e.wword = 32'h0;
    e.widx  = {2'b00, w_ad[31:2]};
    if (e.mis || e.rng) begin
      e.lat = 1;
    end else begin
      idx = int'(w_ad[31:2]);
      w = ref_mem[idx];
      if (!w_we) begin
        e.lat = 2;
        e.n_rd = 1;
        b = get_byte(w, off);
        h = (BE != 0) ? {get_byte(w, off), get_byte(w, off + 1)} : {get_byte(w, off + 1), get_byte(w, off)};
        if (w_sz == SZ_BYTE)      v = w_sg ? {{24{b[7]}}, b} : {24'h0, b};
        else if (w_sz == SZ_HALF) v = w_sg ? {{16{h[15]}}, h} : {16'h0, h};
        else                      v = w;
        e.rdata = v;
        last_rdata = v;
      end else begin
        e.n_wr = 1;
        if (w_sz == SZ_WORD) begin
          e.lat = 2;
          w = w_wd;
        end else if (w_sz == SZ_BYTE) begin
          e.lat = 3; e.n_rd = 1;
          w = put_byte(w, off, w_wd[7:0]);
        end else begin
          e.lat = 3; e.n_rd = 1;
          w = put_byte(w, off, (BE != 0) ? w_wd[15:8] : w_wd[7:0]);
          w = put_byte(w, off + 1, (BE != 0) ? w_wd[7:0] : w_wd[15:8]);
        end
        ref_mem[idx] = w;
        e.wword = w;
      end
    end
    sb.push_back(e);

    @(negedge clk);
    req = 1'b1; we = w_we; size = w_sz; sgn = w_sg; addr = w_ad; wdata = w_wd;
    @(posedge clk);
    #1;
    // Scramble the request inputs: the DUT must work from its latched copies.
    req = 1'b0; we = ~w_we; size = 2'($urandom); sgn = ~w_sg; addr = $urandom; wdata = $urandom;
    lat = 1; nwr = 0; nrd = 0; got_wd = 32'h0; got_wa = 32'h0;
    forever begin
      if (mem_write) begin nwr++; got_wd = mem_wdata; got_wa = mem_addr; end
      if (mem_read) nrd++;
      if (done || lat >= 8) break;
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk("done",      {31'h0, done}, 32'h1);
    chk("busy_done", {31'h0, busy}, 32'h1);
    chk("latency",   lat, e.lat);
    chk("rdata",     rdata, e.rdata);
    chk("misalign",  {31'h0, misalign}, {31'h0, e.mis});
    chk("range_err", {31'h0, range_err}, {31'h0, e.rng});
    chk("n_write",   nwr, e.n_wr);
    chk("n_read",    nrd, e.n_rd);
    if (e.n_wr != 0) begin
      chk("wr_data", got_wd, e.wword);
      chk("wr_addr", got_wa, e.widx);
    end
    @(posedge clk);
    #1;
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("done_idle", {31'h0, done}, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_flags"}, {30'h0, misalign, range_err}, 32'h0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
    chk({tag, "_mwdata"}, mem_wdata, 32'h0);
    chk({tag, "_strobes"}, {30'h0, mem_write, mem_read}, 32'h0);
  endtask

  initial begin
    int dcnt, first_d, last_d, gap_bad, wcnt;
    logic [1:0] rs;
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) preload(i, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Word store then load back
    access(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF);
    chk("t1_mem", mem[2], 32'hDEADBEEF);
    access(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);

    // Byte store via read-modify-write
    preload(2, 32'h11223344);
    access(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h000000AA);
    chk("t2_mem", mem[2], 32'h11AA3344);

    // Load extension cases
    preload(2, 32'h80FF7F01);
    access(1'b0, SZ_BYTE, 1'b1, 32'h8, 32'h0);
    access(1'b0, SZ_BYTE, 1'b0, 32'h8, 32'h0);
    access(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0);
    access(1'b0, SZ_HALF, 1'b1, 32'h8, 32'h0);
    access(1'b0, SZ_HALF, 1'b0, 32'h8, 32'h0);
    access(1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0);
    access(1'b1, SZ_HALF, 1'b0, 32'hA, 32'h0000BEEF);
    chk("t3_mem", mem[2], 32'h80FFBEEF);

    // Faults
    access(1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0);
    access(1'b1, SZ_HALF, 1'b0, 32'h3, 32'h1234);
    access(1'b0, 2'b11,   1'b0, 32'h8, 32'h0);
    access(1'b1, SZ_WORD, 1'b0, 32'h80, 32'hCAFEBABE);
    access(1'b0, SZ_BYTE, 1'b0, 32'hFFFF_FFFF, 32'h0);
    chk("t4_mem0", mem[0], 32'h0);

    // Random aligned traffic within range
    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = {25'h0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (rs == SZ_BYTE) ra[1:0] = 2'($urandom);
      if (rs == SZ_HALF) ra[1] = 1'($urandom);
      access(1'($urandom), rs, 1'($urandom), ra, $urandom);
    end
    for (int i = 0; i < DEPTH; i++) chk("rand_mem", mem[i], ref_mem[i]);

    // Reset in the middle of a read-modify-write
    preload(3, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = SZ_BYTE; sgn = 1'b0; addr = 32'hD; wdata = 32'h55;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("t5_rmw_read", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("t5");
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_mem", mem[3], 32'hCAFEF00D);
    chk("t5_strobe", {30'h0, mem_write, mem_read}, 32'h0);

    // Continuous request, alternating load/store at each completion
    preload(4, 32'hA5A5A5A5);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = SZ_WORD; sgn = 1'b0; addr = 32'h10; wdata = 32'h12345678;
    dcnt = 0; first_d = -1; last_d = -1; gap_bad = 0; wcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (mem_write) wcnt++;
      if (done) begin
        if (dcnt == 1) chk("t6_first_load", rdata, 32'hA5A5A5A5);
        if (last_d >= 0 && c - last_d != 3) gap_bad++;
        if (first_d < 0) first_d = c;
        last_d = c;
        dcnt++;
        @(negedge clk);
        we = ~we;
      end
    end
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_done_count", dcnt, 4);
    chk("t6_first_done", first_d, 1);
    chk("t6_gap", gap_bad, 0);
    chk("t6_writes", wcnt, 2);
    chk("t6_mem", mem[4], 32'h12345678);
    chk("t6_rdata", rdata, 32'h12345678);
    chk("t6_busy", {31'h0, busy}, 32'h0);

    chk("rd_wr_overlap", both_cnt, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
